// File: rtl/n64_pkg.sv
// Shared constants, state encoding and stick shaping helper for the N64 pad decoder.
package n64_pkg;

    // Button bit positions inside the 16-bit button field of a report.
    localparam int unsigned BTN_A     = 0;
    localparam int unsigned BTN_B     = 1;
    localparam int unsigned BTN_Z     = 2;
    localparam int unsigned BTN_START = 3;
    localparam int unsigned BTN_DU    = 4;
    localparam int unsigned BTN_DD    = 5;
    localparam int unsigned BTN_DL    = 6;
    localparam int unsigned BTN_DR    = 7;
    localparam int unsigned BTN_L     = 10;
    localparam int unsigned BTN_R     = 11;
    localparam int unsigned BTN_CU    = 12;
    localparam int unsigned BTN_CD    = 13;
    localparam int unsigned BTN_CL    = 14;
    localparam int unsigned BTN_CR    = 15;

    // Bits 8 and 9 carry no button and are forced to 0 before any use.
    localparam logic [15:0] RSVD_MASK = 16'h0300;

    // Event word = {press, button index}.
    localparam int unsigned EV_IDX_W = 4;
    localparam int unsigned EV_W     = EV_IDX_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_SCAN  = 2'd2
    } dec_state_e;

    // Dead-zone then saturate a two's complement stick value.
    // The magnitude is 9 bits wide so that -128 yields +128 rather than wrapping.
    function automatic logic [7:0] shape_stick(input logic [7:0] v,
                                               input int unsigned dz,
                                               input int unsigned smax);
        logic [8:0] sv;
        logic [8:0] mag;
        logic [8:0] lim;
        logic [7:0] r;
        sv  = {v[7], v};
        mag = sv[8] ? (~sv + 9'd1) : sv;
        lim = 9'(smax);
        if (mag <= 9'(dz)) begin
            r = 8'd0;
        end else if (mag > lim) begin
            r = sv[8] ? (~lim[7:0] + 8'd1) : lim[7:0];
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/n64_pad_decoder_fifo.sv
// Small synchronous event FIFO; a pop on a full FIFO frees room for a same-cycle push.
module n64_event_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    // Pop only when something is there; push when room exists or a pop frees a slot.
    always_comb begin
        do_pop  = pop_i && (count_q != '0);
        do_push = push_i && ((count_q != FULL_CNT) || do_pop);
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents need no reset because occupancy gates visibility.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/n64_pad_decoder.sv
// N64 report decoder: debounced buttons, shaped sticks, link watchdog, button event FIFO.
// Handshake: report_valid is a one-cycle strobe with no backpressure (busy reports go to a
// one-deep pending slot); an event is transferred when ev_valid && ev_rd at a PCLK edge.
module n64_pad_decoder
    import n64_pkg::*;
#(
    parameter int unsigned DEBOUNCE_N     = 2,
    parameter int unsigned DEADZONE       = 8,
    parameter int unsigned STICK_MAX      = 80,
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 2500000
) (
    input  logic            PCLK,
    input  logic            PRESET,
    input  logic            report_valid,
    input  logic [31:0]     report_data,
    output logic [15:0]     btn_state,
    output logic [7:0]      stick_x,
    output logic [7:0]      stick_y,
    output logic            link_ok,
    output logic            ev_valid,
    output logic [EV_W-1:0] ev_data,
    input  logic            ev_rd,
    output logic            ev_overflow,
    input  logic            ev_ovf_clr,
    output logic [7:0]      drop_count,
    output dec_state_e      dbg_state
);
    localparam int unsigned   TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] T_MAX   = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] T_ONE   = 1;
    localparam logic [3:0]    DEB_CNT = 4'(DEBOUNCE_N);

    dec_state_e          state_q;
    logic [31:0]         work_q;
    logic [31:0]         pend_q;
    logic                pend_full_q;
    logic [15:0]         last_raw_q;
    logic [3:0]          stab_cnt_q;
    logic [15:0]         btn_q;
    logic [15:0]         diff_q;
    logic [3:0]          idx_q;
    logic [7:0]          sx_q;
    logic [7:0]          sy_q;
    logic                link_ok_q;
    logic [TW-1:0]       timer_q;
    logic                ovf_q;
    logic [7:0]          drop_q;

    logic [15:0]         field_d;
    logic [3:0]          stab_cnt_d;
    logic [7:0]          raw_x;
    logic [7:0]          raw_y;
    logic                ev_push;
    logic [EV_W-1:0]     ev_push_data;
    logic                ev_drop;
    logic                drop_inc;
    logic                fifo_full;
    logic                fifo_empty;

    // Field extraction, debounce counter preview and event push decode.
    always_comb begin
        field_d    = work_q[15:0] & ~RSVD_MASK;
        stab_cnt_d = (field_d == last_raw_q)
                   ? ((stab_cnt_q == 4'd15) ? 4'd15 : stab_cnt_q + 4'd1)
                   : 4'd1;
        for (int i = 0; i < 8; i++) begin
            raw_x[7-i] = work_q[16+i];
            raw_y[7-i] = work_q[24+i];
        end
        ev_push      = (state_q == ST_SCAN) && diff_q[idx_q];
        ev_push_data = {btn_q[idx_q], idx_q};
        ev_drop      = ev_push && fifo_full && !ev_rd;
        drop_inc     = report_valid && pend_full_q;
    end

    // Main controller: report intake, debounce/compare, event scan, link watchdog.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= ST_IDLE;
            work_q      <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            last_raw_q  <= '0;
            stab_cnt_q  <= '0;
            btn_q       <= '0;
            diff_q      <= '0;
            idx_q       <= '0;
            sx_q        <= '0;
            sy_q        <= '0;
            link_ok_q   <= 1'b0;
            timer_q     <= '0;
            ovf_q       <= 1'b0;
            drop_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A fresh report beats a stale pending one.
                    if (report_valid) begin
                        work_q      <= report_data;
                        pend_full_q <= 1'b0;
                        state_q     <= ST_CHECK;
                    end else if (pend_full_q) begin
                        work_q      <= pend_q;
                        pend_full_q <= 1'b0;
                        state_q     <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    last_raw_q <= field_d;
                    stab_cnt_q <= stab_cnt_d;
                    sx_q       <= shape_stick(raw_x, DEADZONE, STICK_MAX);
                    sy_q       <= shape_stick(raw_y, DEADZONE, STICK_MAX);
                    if ((stab_cnt_d >= DEB_CNT) && (field_d != btn_q)) begin
                        diff_q  <= field_d ^ btn_q;
                        btn_q   <= field_d;
                        idx_q   <= '0;
                        state_q <= ST_SCAN;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_SCAN: begin
                    idx_q <= idx_q + 4'd1;
                    if (idx_q == 4'd15) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase

            if (report_valid && (state_q != ST_IDLE)) begin
                pend_q      <= report_data;
                pend_full_q <= 1'b1;
            end

            if (drop_inc && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;

            // A drop in the same cycle as a clear must stay visible.
            if (ev_drop) begin
                ovf_q <= 1'b1;
            end else if (ev_ovf_clr) begin
                ovf_q <= 1'b0;
            end

            // Watchdog fires once and then parks; its forcing overrides a same-cycle CHECK.
            if (report_valid) begin
                timer_q   <= '0;
                link_ok_q <= 1'b1;
            end else if (timer_q == T_LAST) begin
                timer_q    <= T_MAX;
                link_ok_q  <= 1'b0;
                btn_q      <= '0;
                sx_q       <= '0;
                sy_q       <= '0;
                stab_cnt_q <= '0;
            end else if (timer_q != T_MAX) begin
                timer_q <= timer_q + T_ONE;
            end
        end
    end

    n64_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EV_W)
    ) u_fifo (
        .clk_i       (PCLK),
        .rst_i       (PRESET),
        .push_i      (ev_push),
        .push_data_i (ev_push_data),
        .pop_i       (ev_rd),
        .head_o      (ev_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign btn_state   = btn_q;
    assign stick_x     = sx_q;
    assign stick_y     = sy_q;
    assign link_ok     = link_ok_q;
    assign ev_valid    = !fifo_empty;
    assign ev_overflow = ovf_q;
    assign drop_count  = drop_q;
    assign dbg_state   = state_q;

endmodule

// File: doc/n64_pad_decoder.md
Name: n64_pad_decoder

Overview:
- Downstream stage of the N64 controller line interface; consumes each completed 32-bit controller report.
- Produces debounced button state, bit-order-corrected and dead-zoned stick values, a link-alive flag, and a FIFO of per-button press/release events for firmware or motor-control logic.

Parameters:
- DEBOUNCE_N, 2: consecutive identical button fields needed before btn_state updates (1..15).
- DEADZONE, 8: stick magnitude <= DEADZONE reads as 0.
- STICK_MAX, 80: stick output is saturated to +/-STICK_MAX.
- FIFO_DEPTH, 8: event FIFO entries (power of 2).
- TIMEOUT_CYCLES, 2500000: cycles without a report before link_ok drops (100 ms at 25 MHz).

Ports:
- PCLK  in  1  system clock.
- PRESET  in  1  synchronous active-high reset.
- report_valid  in  1  one-cycle pulse; report_data is valid in that cycle.
- report_data  in  32  raw report; bit i = i-th received line bit.
- btn_state  out  16  debounced buttons, 1 = pressed; indexed like report_data[15:0].
- stick_x  out  8  signed, dead-zoned, saturated.
- stick_y  out  8  signed, dead-zoned, saturated.
- link_ok  out  1  a report was seen within TIMEOUT_CYCLES.
- ev_valid  out  1  FIFO not empty.
- ev_data  out  5  {press=1/release=0, button index[3:0]}; head entry, valid when ev_valid=1.
- ev_rd  in  1  pop the head entry; ignored when empty.
- ev_overflow  out  1  sticky; an event was dropped because the FIFO was full.
- ev_ovf_clr  in  1  clears ev_overflow.
- drop_count  out  8  saturating count of reports discarded while busy.

Behaviour:
- Reset (PRESET=1 at a PCLK edge): every output 0, FIFO empty, debounce counter 0, pending slot empty, FSM in IDLE.
- Raw report is active-high (1 = pressed); no inversion is applied.
- Button field = report_data[15:0]. Bits 8 and 9 are masked to 0 before any use.
- Stick X: raw_x[7:0] = {report_data[16], report_data[17], ..., report_data[23]}. report_data[16] is the MSB.
- Stick Y: raw_y built the same way from report_data[24..31].
- Stick processing, applied to raw_x and raw_y as two's complement:
  - if |v| <= DEADZONE, output 0;
  - else if v > STICK_MAX, output STICK_MAX;
  - else if v < -STICK_MAX, output -STICK_MAX;
  - else output v.
  - Compute |v| 9 bits wide so -128 is handled without overflow.
- Stick outputs register 1 cycle after an accepted report enters CHECK. Sticks are not debounced.
- FSM states: IDLE, CHECK, SCAN.
- IDLE:
  - on report_valid, latch the report into the work register and go to CHECK;
  - else, if the pending slot is full, move it to the work register, clear the slot, and go to CHECK.
- CHECK (1 cycle):
  - if the button field equals last_raw, increment stab_cnt (saturating at 15); else load last_raw and set stab_cnt = 1;
  - compute new_cnt = the value stab_cnt will hold after this update;
  - if new_cnt >= DEBOUNCE_N and the field differs from btn_state, latch diff = field XOR btn_state, update btn_state, set idx = 0, go to SCAN;
  - otherwise go to IDLE.
- SCAN (exactly 16 cycles, idx 0..15):
  - if diff[idx]=1, push {btn_state[idx], idx};
  - if the FIFO is full, drop the event and set ev_overflow;
  - at idx = 15 go to IDLE.
- Event order is ascending button index.
- Latency from report_valid to the first event visible on ev_valid: 3 cycles, assuming no backlog.
- report_valid while not in IDLE:
  - store the report in the one-deep pending slot; a newer report overwrites an older one;
  - each overwrite increments drop_count, saturating at 255.
- report_valid in IDLE with the pending slot full: the new report wins and the pending report is dropped (+1 drop_count).
- FIFO:
  - push and pop in the same cycle when full: the pop happens first and the push succeeds;
  - push and pop in the same cycle when empty: ev_valid rises next cycle;
  - ev_data is undefined when ev_valid=0.
- ev_overflow set and ev_ovf_clr in the same cycle: set wins.
- Link timer:
  - cleared to 0 on every report_valid, and link_ok is set to 1;
  - if the timer reaches TIMEOUT_CYCLES, link_ok is cleared, btn_state, stick_x and stick_y are forced to 0, and stab_cnt is cleared;
  - no release events are generated on timeout.
- PRESET mid-SCAN aborts the scan. Events already pushed are discarded.

Decomposition:
- Package n64_pkg holds:
  - button index constants (A=0, B=1, Z=2, START=3, DU=4, DD=5, DL=6, DR=7, L=10, R=11, CU=12, CD=13, CL=14, CR=15);
  - RSVD_MASK = 16'h0300;
  - event field widths;
  - the FSM state encoding.
- One sub-module, n64_event_fifo: synchronous FIFO with push, pop, full, empty.

Test Plan:
- Reset, then report 32'h0000_0001 twice (DEBOUNCE_N=2) -> btn_state=16'h0001; one event 5'b1_0000; ev_valid 3 cycles after the second pulse.
- From A pressed, report 32'h0000_0802 twice -> events in order {0,0} (A released), {1,1} (B pressed), {1,11} (R pressed).
- Single report 32'h0000_0004 followed by 32'h0 -> no btn_state change, no events.
- Stick checks:
  - X bits 16..23 = 0,1,1,1,1,1,1,1 (raw +127) -> stick_x = 80;
  - raw -5 -> stick_x = 0;
  - raw 8'h80 -> stick_x = -80.
- Report 16'hFFFF buttons twice with FIFO_DEPTH=8 and no pops -> 8 events queued (reserved bits 8,9 excluded), ev_overflow=1; then ev_ovf_clr -> ev_overflow=0.
- No reports for TIMEOUT_CYCLES -> link_ok=0, btn_state=0, sticks 0. Two reports 5 cycles apart while in SCAN -> drop_count=1 and the later report is processed.
